// File: rtl/mmc_cmd_serialiser.sv
// MMC command-line serialiser: frames {start, tx, index, argument, crc7, end} and shifts it
// out MSB first on bitclk falling edges. Define MMC_CMD_SERIALISER_CRC_EN to generate crc7.
module mmc_cmd_serialiser (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        bitclk_i,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [5:0]  cmd_i,
    input  logic [31:0] arg_i,
    output logic        cmd_o,
    output logic        cmd_oe_o,
    output logic        active_o,
    output logic        complete_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_END   = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic        clk_q_r;
    logic        shift_s;
    logic [47:0] sreg_r;
    logic [47:0] sreg_nxt_s;
    logic [5:0]  bit_cnt_r;
    logic [5:0]  bit_cnt_nxt_s;
    logic        cmd_nxt_s;
    logic        oe_nxt_s;
    logic        active_nxt_s;
    logic        complete_nxt_s;
    logic [6:0]  crc_s;
    logic [47:0] frame_s;

`ifdef MMC_CMD_SERIALISER_CRC_EN
    // Bit-serial CRC7 (x^7 + x^3 + 1), MSB first, zero seed.
    function automatic logic [6:0] crc7_calc(input logic [39:0] data);
        logic [6:0] crc;
        logic       fb;
        crc = 7'h00;
        for (int i = 39; i >= 0; i--) begin
            fb  = data[i] ^ crc[6];
            crc = {crc[5:0], 1'b0};
            if (fb) begin
                crc = crc ^ 7'h09;
            end else begin
                crc = crc;
            end
        end
        return crc;
    endfunction

    assign crc_s = crc7_calc({2'b01, cmd_i, arg_i});
`else
    assign crc_s = 7'h7F;
`endif

    assign frame_s = {1'b0, 1'b1, cmd_i, arg_i, crc_s, 1'b1};
    assign shift_s = ~bitclk_i & clk_q_r;

    // Next-state, shift register, bit counter and output decode.
    always_comb begin
        state_nxt_s   = state_r;
        sreg_nxt_s    = sreg_r;
        bit_cnt_nxt_s = bit_cnt_r;
        cmd_nxt_s     = cmd_o;
        oe_nxt_s      = cmd_oe_o;
        if (abort_i) begin
            state_nxt_s = ST_IDLE;
            oe_nxt_s    = 1'b0;
            cmd_nxt_s   = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    oe_nxt_s  = 1'b0;
                    cmd_nxt_s = 1'b1;
                    if (start_i) begin
                        state_nxt_s   = ST_WAIT;
                        sreg_nxt_s    = frame_s;
                        bit_cnt_nxt_s = 6'd47;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (shift_s) begin
                        state_nxt_s = ST_SHIFT;
                        oe_nxt_s    = 1'b1;
                        cmd_nxt_s   = sreg_r[47];
                    end else begin
                        state_nxt_s = ST_WAIT;
                    end
                end
                ST_SHIFT: begin
                    if (shift_s) begin
                        if (bit_cnt_r == 6'd0) begin
                            state_nxt_s = ST_END;
                            oe_nxt_s    = 1'b0;
                            cmd_nxt_s   = 1'b1;
                        end else begin
                            sreg_nxt_s    = {sreg_r[46:0], 1'b0};
                            cmd_nxt_s     = sreg_r[46];
                            bit_cnt_nxt_s = bit_cnt_r - 6'd1;
                        end
                    end else begin
                        state_nxt_s = ST_SHIFT;
                    end
                end
                ST_END: begin
                    state_nxt_s = ST_IDLE;
                    oe_nxt_s    = 1'b0;
                    cmd_nxt_s   = 1'b1;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    oe_nxt_s    = 1'b0;
                    cmd_nxt_s   = 1'b1;
                end
            endcase
        end
        active_nxt_s   = (state_nxt_s != ST_IDLE);
        complete_nxt_s = (state_nxt_s == ST_END);
    end

    // State, datapath and registered outputs; reset releases the line asynchronously.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r    <= ST_IDLE;
            clk_q_r    <= 1'b0;
            bit_cnt_r  <= 6'd47;
            sreg_r     <= 48'd0;
            cmd_o      <= 1'b1;
            cmd_oe_o   <= 1'b0;
            active_o   <= 1'b0;
            complete_o <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            clk_q_r    <= bitclk_i;
            bit_cnt_r  <= bit_cnt_nxt_s;
            sreg_r     <= sreg_nxt_s;
            cmd_o      <= cmd_nxt_s;
            cmd_oe_o   <= oe_nxt_s;
            active_o   <= active_nxt_s;
            complete_o <= complete_nxt_s;
        end
    end

endmodule

// File: tb/tb_mmc_cmd_serialiser.sv
// Directed bench for mmc_cmd_serialiser: table of command frames plus abort, re-start,
// reset and start-on-edge sequences. Expected CRC bytes follow MMC_CMD_SERIALISER_CRC_EN.
module tb_mmc_cmd_serialiser;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bitclk = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [5:0]  cmd = 6'd0;
    logic [31:0] arg = 32'd0;
    logic        cmd_o;
    logic        cmd_oe_o;
    logic        active_o;
    logic        complete_o;

    int          errors = 0;
    int          checks = 0;
    logic [47:0] cap_bits = 48'd0;
    int          cap_cnt = 0;
    int          comp_cnt = 0;
    logic        prev_bclk = 1'b1;

    typedef struct {
        logic [5:0]  cmd;
        logic [31:0] arg;
        logic [47:0] frame;
    } vec_t;

    vec_t vecs [5];

    mmc_cmd_serialiser dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .bitclk_i   (bitclk),
        .start_i    (start),
        .abort_i    (abort),
        .cmd_i      (cmd),
        .arg_i      (arg),
        .cmd_o      (cmd_o),
        .cmd_oe_o   (cmd_oe_o),
        .active_o   (active_o),
        .complete_o (complete_o)
    );

    always #5 clk = ~clk;

    // Bit clock: 8 system clocks per period, edges 2 time units after a rising clk edge.
    initial begin
        forever begin
            repeat (4) @(posedge clk);
            #2 bitclk = ~bitclk;
        end
    end

    // Card-side monitor: sample CMD on bitclk rising edges while driven, count completes.
    initial begin
        forever begin
            @(negedge clk);
            if (bitclk && !prev_bclk && cmd_oe_o) begin
                cap_bits = {cap_bits[46:0], cmd_o};
                cap_cnt++;
            end
            if (complete_o) comp_cnt++;
            prev_bclk = bitclk;
        end
    end

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        cap_cnt  = 0;
        cap_bits = 48'd0;
        comp_cnt = 0;
    endtask

    task automatic pulse_start(input logic [5:0] c, input logic [31:0] a);
        @(negedge clk);
        cmd   = c;
        arg   = a;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_bits(input int n);
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (cap_cnt >= n) break;
        end
    endtask

    task automatic wait_done();
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (comp_cnt != 0) break;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_oe"}, {47'd0, cmd_oe_o}, 48'd0);
        chk({tag, "_cmd"}, {47'd0, cmd_o}, 48'd1);
        chk({tag, "_active"}, {47'd0, active_o}, 48'd0);
    endtask

    initial begin
`ifdef MMC_CMD_SERIALISER_CRC_EN
        vecs[0] = '{6'd0,  32'h0000_0000, 48'h40_0000_0000_95};
        vecs[1] = '{6'd8,  32'h0000_01AA, 48'h48_0000_01AA_87};
        vecs[2] = '{6'd17, 32'h0000_0000, 48'h51_0000_0000_55};
        vecs[3] = '{6'd55, 32'h0000_0000, 48'h77_0000_0000_65};
        vecs[4] = '{6'd41, 32'h4000_0000, 48'h69_4000_0000_77};
`else
        vecs[0] = '{6'd0,  32'h0000_0000, 48'h40_0000_0000_FF};
        vecs[1] = '{6'd8,  32'h0000_01AA, 48'h48_0000_01AA_FF};
        vecs[2] = '{6'd17, 32'h0000_0000, 48'h51_0000_0000_FF};
        vecs[3] = '{6'd55, 32'h0000_0000, 48'h77_0000_0000_FF};
        vecs[4] = '{6'd41, 32'h4000_0000, 48'h69_4000_0000_FF};
`endif

        repeat (3) @(negedge clk);
        chk("rst_oe", {47'd0, cmd_oe_o}, 48'd0);
        chk("rst_cmd", {47'd0, cmd_o}, 48'd1);
        chk("rst_active", {47'd0, active_o}, 48'd0);
        chk("rst_complete", {47'd0, complete_o}, 48'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            pulse_start(vecs[v].cmd, vecs[v].arg);
            clear_mon();
            @(negedge clk);
            chk($sformatf("v%0d_active", v), {47'd0, active_o}, 48'd1);
            wait_done();
            chk($sformatf("v%0d_frame", v), cap_bits, vecs[v].frame);
            chk($sformatf("v%0d_nbits", v), 48'(cap_cnt), 48'd48);
            chk($sformatf("v%0d_complete", v), 48'(comp_cnt), 48'd1);
            check_idle($sformatf("v%0d_after", v));
        end

        // Abort after 20 bits.
        pulse_start(vecs[1].cmd, vecs[1].arg);
        clear_mon();
        wait_bits(20);
        chk("abort_oe_before", {47'd0, cmd_oe_o}, 48'd1);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check_idle("abort");
        repeat (200) @(negedge clk);
        chk("abort_no_complete", 48'(comp_cnt), 48'd0);
        chk("abort_bits", 48'(cap_cnt), 48'd20);

        // Re-start mid-frame with a different command must not disturb the frame.
        pulse_start(vecs[0].cmd, vecs[0].arg);
        clear_mon();
        wait_bits(10);
        pulse_start(6'd17, 32'hDEAD_BEEF);
        wait_done();
        chk("restart_frame", cap_bits, vecs[0].frame);
        chk("restart_complete", 48'(comp_cnt), 48'd1);

        // Start and abort in the same idle cycle: nothing is sent.
        clear_mon();
        @(negedge clk);
        cmd   = 6'd8;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check_idle("start_abort");
        repeat (200) @(negedge clk);
        chk("start_abort_bits", 48'(cap_cnt), 48'd0);
        chk("start_abort_complete", 48'(comp_cnt), 48'd0);

        // Start coinciding with a bitclk falling edge still waits a full bit period.
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!bitclk && prev_bclk) break;
        end
        cmd   = vecs[2].cmd;
        arg   = vecs[2].arg;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        clear_mon();
        repeat (4) @(negedge clk);
        chk("edge_start_oe", {47'd0, cmd_oe_o}, 48'd0);
        chk("edge_start_active", {47'd0, active_o}, 48'd1);
        wait_done();
        chk("edge_start_frame", cap_bits, vecs[2].frame);
        chk("edge_start_complete", 48'(comp_cnt), 48'd1);

        // Reset mid-frame releases the line without a clock edge.
        pulse_start(vecs[3].cmd, vecs[3].arg);
        clear_mon();
        wait_bits(10);
        #2 rst = 1'b1;
        #1;
        chk("midrst_oe", {47'd0, cmd_oe_o}, 48'd0);
        chk("midrst_cmd", {47'd0, cmd_o}, 48'd1);
        chk("midrst_active", {47'd0, active_o}, 48'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        chk("midrst_no_complete", 48'(comp_cnt), 48'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mmc_cmd_serialiser.md
MMC_CMD_SERIALISER -- requirements
Module: mmc_cmd_serialiser

Interface
REQ-001 The block SHALL have clock clk_i and reset rst_i (asynchronous, active-high).
REQ-002 The ports SHALL be as follows (name, direction, width, meaning):
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous active-high reset.
- bitclk_i  in  1  MMC bit clock level, sampled on clk_i.
- start_i  in  1  one-cycle request to send a command.
- abort_i  in  1  cancel any transfer in progress.
- cmd_i  in  6  command index, sampled when start_i is accepted.
- arg_i  in  32  command argument, sampled when start_i is accepted.
- cmd_o  out  1  serial CMD line data.
- cmd_oe_o  out  1  CMD line output enable.
- active_o  out  1  transfer in progress (state != IDLE).
- complete_o  out  1  one-cycle pulse when the frame is done.

Function
REQ-003 The block SHALL register bitclk_i into clk_q and define shift_w = ~bitclk_i & clk_q, i.e. the bitclk falling edge.
REQ-004 The frame SHALL be 48 bits, sent MSB first: {1'b0 start, 1'b1 transmit, cmd_i[5:0], arg_i[31:0], crc7[6:0], 1'b1 end}.
REQ-005 crc7 SHALL use polynomial x^7+x^3+1 with initial value 7'h00, computed over frame bits [47:8] (40 bits).
REQ-006 The state machine SHALL have states IDLE, WAIT, SHIFT and END, with these transitions:
- IDLE->WAIT on start_i.
- WAIT->SHIFT on shift_w.
- SHIFT->END on shift_w when bit_cnt==0.
- END->IDLE unconditionally after one cycle.
REQ-007 When start_i is accepted in IDLE, the block SHALL load the 48-bit frame into a shift register and set bit_cnt to 6'd47.
REQ-008 start_i SHALL be ignored in every state other than IDLE, and the loaded frame SHALL NOT change.
REQ-009 On the WAIT->SHIFT edge, the block SHALL assert cmd_oe_o and drive cmd_o = frame bit 47.
REQ-010 On each following shift_w in SHIFT, the block SHALL shift the frame left, drive the next bit, and decrement bit_cnt.
REQ-011 Each bit SHALL be held for exactly one full bitclk period (falling edge to falling edge), so the card samples it on the rising edge.
REQ-012 On the shift_w that ends bit 0, the block SHALL enter END, deassert cmd_oe_o and set cmd_o to 1.
REQ-013 complete_o SHALL be high only in END, for exactly one clk_i cycle.
REQ-014 Whenever cmd_oe_o is 0, cmd_o SHALL be 1 (idle-high line).
REQ-015 abort_i SHALL force next state IDLE from any state and take priority over all other transitions.
REQ-016 After an abort, cmd_oe_o SHALL be 0 on the next cycle and complete_o SHALL NOT pulse.
REQ-017 If start_i and abort_i are asserted in the same IDLE cycle, abort SHALL win: the state stays IDLE and no frame is sent.
REQ-018 If shift_w and start_i coincide in IDLE, the first bit SHALL still wait for the next falling edge (through WAIT).
REQ-019 bit_cnt SHALL be 6 bits wide and SHALL NOT underflow; it is reloaded only on start.

Reset
REQ-020 On rst_i, the block SHALL set:
- state = IDLE, clk_q = 0, bit_cnt = 6'd47, shift register = 48'b0.
- cmd_o = 1, cmd_oe_o = 0, active_o = 0, complete_o = 0.
REQ-021 Reset asserted mid-frame SHALL release the CMD line (cmd_oe_o = 0) immediately and asynchronously.

Configuration
REQ-022 The macro MMC_CMD_SERIALISER_CRC_EN SHALL select how the crc7 field is produced:
- Defined: the crc7 field is generated per REQ-005.
- Undefined: no CRC logic is built and the crc7 field is 7'h7F (host CRC checking is disabled by the card in SPI-style debug flows).

Verification
REQ-023 With CRC_EN, cmd_i=0 and arg_i=0 -> 48 bits 0x40_0000_0000_95 on cmd_o, then complete_o pulses once.
REQ-024 With CRC_EN, cmd_i=8 and arg_i=0x000001AA -> frame 0x48_0000_01AA_87.
REQ-025 With CRC_EN, cmd_i=17 and arg_i=0 -> frame 0x51_0000_0000_55.
REQ-026 abort_i asserted after 20 bits have been shifted -> cmd_oe_o=0 and cmd_o=1 on the next cycle, no complete_o, and active_o=0.
REQ-027 start_i re-pulsed mid-frame with a different cmd_i -> the original frame is transmitted unchanged.
REQ-028 Without CRC_EN, cmd_i=0 and arg_i=0 -> frame 0x40_0000_0000_FF.
